// File: rtl/storage_access_arbiter_pkg.sv
// storage_access_arbiter_pkg: grant and FSM encodings plus default timing constants
// shared by the storage access arbiter and its priority selector.
package storage_access_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SYM  = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } gnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int DEF_SYM_HOLD  = 2;
    localparam int DEF_WR_HOLD   = 2;
    localparam int DEF_RD_HOLD   = 153;
    localparam int DEF_SYM_BURST = 4;
    localparam int DEF_HOLD_W    = 8;
    localparam int DEF_STAT_W    = 16;

endpackage

// File: rtl/arb_priority_sel.sv
// arb_priority_sel: picks the next storage access winner from the eligible requesters,
// the symbol streak and the host alternation state.
module arb_priority_sel
    import storage_access_arbiter_pkg::*;
#(
    parameter int SYM_BURST = DEF_SYM_BURST,
    parameter int SW        = $clog2(DEF_SYM_BURST + 1)
) (
    input  logic          sym_e,
    input  logic          wr_e,
    input  logic          rd_e,
    input  logic [SW-1:0] streak,
    input  logic          last_rd,
    output gnt_t          win
);
    logic host_win;

    // Host only pre-empts symbols once the burst allowance is used up.
    assign host_win = (wr_e | rd_e) & (!sym_e | streak == SW'(SYM_BURST));

    always_comb
        win = host_win ? ((wr_e & (!rd_e | last_rd)) ? GNT_WR : GNT_RD)
                       : (sym_e ? GNT_SYM : GNT_NONE);

endmodule

// File: rtl/storage_access_arbiter.sv
// storage_access_arbiter: serialises symbol pushes, host writes and host reads onto the
// symbol storage array. Define STORAGE_ARB_STATS_EN for the statistics counters.
module storage_access_arbiter
    import storage_access_arbiter_pkg::*;
#(
    parameter int SYM_HOLD  = DEF_SYM_HOLD,
    parameter int WR_HOLD   = DEF_WR_HOLD,
    parameter int RD_HOLD   = DEF_RD_HOLD,
    parameter int SYM_BURST = DEF_SYM_BURST,
    parameter int HOLD_W    = DEF_HOLD_W
`ifdef STORAGE_ARB_STATS_EN
    ,
    parameter int STAT_W    = DEF_STAT_W
`endif
) (
    input  logic        sym_clk,
    input  logic        rst_n,
    input  logic        sym_req,
    input  logic        host_wr_req,
    input  logic        host_rd_req,
    input  logic        iq_fifo_empty,
    input  logic        wr_fifo_empty,
    input  logic        rd_fifo_full,
    output logic        new_symbol,
    output logic        write_enable,
    output logic        read_enable,
    output logic        sym_ack,
    output logic        host_wr_ack,
    output logic        host_rd_ack,
    output logic        busy,
    output logic [1:0]  grant_id
`ifdef STORAGE_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_sym_cnt,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_rd_cnt,
    output logic [STAT_W-1:0] stat_starve_cnt
`endif
);
    localparam int SW = $clog2(SYM_BURST + 1);

    state_t            state, state_nx;
    gnt_t              gnt, gnt_nx, ack, ack_nx, win;
    logic [HOLD_W-1:0] cnt, cnt_nx;
    logic [SW-1:0]     streak, streak_nx;
    logic              last_rd, last_rd_nx;
    logic              sym_e, wr_e, rd_e, host_e;

    assign sym_e  = sym_req & !iq_fifo_empty;
    assign wr_e   = host_wr_req & !wr_fifo_empty;
    assign rd_e   = host_rd_req & !rd_fifo_full;
    assign host_e = wr_e | rd_e;

    arb_priority_sel #(.SYM_BURST(SYM_BURST), .SW(SW)) u_sel (
        .sym_e   (sym_e),
        .wr_e    (wr_e),
        .rd_e    (rd_e),
        .streak  (streak),
        .last_rd (last_rd),
        .win     (win)
    );

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        ack_nx     = GNT_NONE;
        cnt_nx     = cnt;
        streak_nx  = streak;
        last_rd_nx = last_rd;
        case (state)
            ST_IDLE: if (win != GNT_NONE) begin
                state_nx   = ST_ISSUE;
                gnt_nx     = win;
                cnt_nx     = (win == GNT_SYM) ? HOLD_W'(SYM_HOLD - 1)
                           : (win == GNT_WR)  ? HOLD_W'(WR_HOLD - 1) : HOLD_W'(RD_HOLD - 1);
                streak_nx  = (win == GNT_SYM && host_e) ? streak + 1'b1 : '0;
                last_rd_nx = (win == GNT_SYM) ? last_rd : (win == GNT_RD);
            end
            ST_ISSUE: state_nx = ST_HOLD;
            ST_HOLD: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == HOLD_W'(1)) begin
                    state_nx = ST_IDLE;
                    ack_nx   = gnt;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sym_clk or negedge rst_n)
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt     <= GNT_NONE;
            ack     <= GNT_NONE;
            cnt     <= '0;
            streak  <= '0;
            last_rd <= 1'b1;
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            ack     <= ack_nx;
            cnt     <= cnt_nx;
            streak  <= streak_nx;
            last_rd <= last_rd_nx;
        end

    assign busy         = state != ST_IDLE;
    assign grant_id     = busy ? gnt : GNT_NONE;
    assign new_symbol   = state == ST_ISSUE && gnt == GNT_SYM;
    assign write_enable = state == ST_ISSUE && gnt == GNT_WR;
    assign read_enable  = state == ST_ISSUE && gnt == GNT_RD;
    assign sym_ack      = ack == GNT_SYM;
    assign host_wr_ack  = ack == GNT_WR;
    assign host_rd_ack  = ack == GNT_RD;

`ifdef STORAGE_ARB_STATS_EN
    logic starve;

    assign starve = state == ST_IDLE && host_e && win == GNT_SYM;

    // All counters saturate at all-ones; clear beats a same-cycle increment.
    always_ff @(posedge sym_clk or negedge rst_n)
        if (!rst_n) begin
            stat_sym_cnt    <= '0;
            stat_wr_cnt     <= '0;
            stat_rd_cnt     <= '0;
            stat_starve_cnt <= '0;
        end else if (stat_clr) begin
            stat_sym_cnt    <= '0;
            stat_wr_cnt     <= '0;
            stat_rd_cnt     <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (sym_ack && ~&stat_sym_cnt) stat_sym_cnt <= stat_sym_cnt + 1'b1;
            if (host_wr_ack && ~&stat_wr_cnt) stat_wr_cnt <= stat_wr_cnt + 1'b1;
            if (host_rd_ack && ~&stat_rd_cnt) stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (starve && ~&stat_starve_cnt) stat_starve_cnt <= stat_starve_cnt + 1'b1;
        end
`endif

endmodule
